// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
//
// Responder end of the instruction-memory bus. The fetch stage presents a
// byte address. Bits [2:0] are ignored, so the address selects one 64-bit
// doubleword. After a fixed number of cycles the block returns that word
// with a one-cycle valid strobe. A program-load port fills the word array
// and works in every state. It never stalls or aborts a fetch.
//
// Parameters
//   DEPTH_LOG2  array holds 2**DEPTH_LOG2 64-bit words
//   LATENCY     cycles from request acceptance to response, legal 1..15
//
// Ports
//   clk              in   rising-edge clock
//   rst_n            in   asynchronous reset, active-low
//   imem_addr        in   [63:0] fetch byte address
//   imem_addr_valid  in   request present; addr held stable until response
//   imem_data        out  [63:0] fetched word, holds last response
//   imem_data_valid  out  one-cycle strobe, imem_data is the requested word
//   imem_fault       out  with imem_data_valid: address outside the array
//   ld_en            in   program-load write enable
//   ld_addr          in   [DEPTH_LOG2-1:0] load word index
//   ld_data          in   [63:0] load word
//   busy             out  request in flight (WAIT state)
// ---------------------------------------------------------------------------
module imem_responder #(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [63:0]           imem_addr,
    input  logic                  imem_addr_valid,
    output logic [63:0]           imem_data,
    output logic                  imem_data_valid,
    output logic                  imem_fault,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [63:0]           ld_data,
    output logic                  busy
);

    localparam int         DEPTH    = 2 ** DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    // With single-cycle latency an accepted request goes straight to RESP.
    localparam bit         DIRECT   = (LATENCY == 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [DEPTH_LOG2-1:0] w_next_idx;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  r_oor;
    logic                  w_next_oor;
    logic                  w_oor;
    logic [3:0]            r_cnt;
    logic [3:0]            w_next_cnt;
    logic                  w_enter_resp;
    logic [63:0]           r_data;
    logic                  r_valid;
    logic                  r_fault;
    logic [63:0]           r_mem [DEPTH];
    logic                  w_unused_addr_lsbs;

    assign w_idx              = imem_addr[DEPTH_LOG2+2:3];
    assign w_oor              = |imem_addr[63:DEPTH_LOG2+3];
    assign w_unused_addr_lsbs = ^imem_addr[2:0];

    // Next-state logic. The "next" index and flag are the values that
    // will be latched at this edge. The array read on RESP entry uses them,
    // so a LATENCY=1 acceptance reads the address being accepted now.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_next_oor   = r_oor;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_IDLE, S_RESP: begin
                if (imem_addr_valid) begin
                    w_next_idx   = w_idx;
                    w_next_oor   = w_oor;
                    w_next_cnt   = CNT_INIT;
                    w_next_state = DIRECT ? S_RESP : S_WAIT;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!imem_addr_valid) begin
                    w_next_state = S_IDLE;
                end else if (w_idx != r_idx) begin
                    // The initiator moved the address. Treat it as a fresh request.
                    w_next_idx   = w_idx;
                    w_next_oor   = w_oor;
                    w_next_cnt   = CNT_INIT;
                    w_next_state = DIRECT ? S_RESP : S_WAIT;
                end else if (r_cnt == 4'd1) begin
                    w_next_state = S_RESP;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_enter_resp = (w_next_state == S_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_oor   <= 1'b0;
            r_cnt   <= 4'd0;
            r_data  <= 64'd0;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here. Every register samples the
            // pre-edge values, including the array read below.
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            r_oor   <= w_next_oor;
            r_cnt   <= w_next_cnt;
            r_valid <= w_enter_resp;
            r_fault <= w_enter_resp & w_next_oor;
            // The read sees the array before any same-edge load lands.
            if (w_enter_resp) begin
                r_data <= w_next_oor ? 64'd0 : r_mem[w_next_idx];
            end
        end
    end

    // NOTE: the word array has no reset. Its contents survive rst_n and come
    // only from the load port, which lets it map onto block RAM.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

    assign imem_data       = r_data;
    assign imem_data_valid = r_valid;
    assign imem_fault      = r_fault;
    assign busy            = (r_state == S_WAIT);

endmodule

// File: tb/tb_imem_responder.sv
// ---------------------------------------------------------------------------
// tb_imem_responder
//
// Three responders share one set of inputs: LATENCY 2, 1 and 3, all with
// DEPTH_LOG2=12. Each fetch targets one of them. A selector picks which
// outputs get compared. Inputs change and outputs are sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_imem_responder;

    logic        clk;
    logic        rst_n;
    logic [63:0] imem_addr;
    logic        imem_addr_valid;
    logic        ld_en;
    logic [11:0] ld_addr;
    logic [63:0] ld_data;

    // Output index 0: LATENCY=2, index 1: LATENCY=1, index 2: LATENCY=3.
    logic [63:0] d [3];
    logic        v [3];
    logic        f [3];
    logic        b [3];

    int n_checks = 0;
    int n_fail   = 0;

    imem_responder #(.DEPTH_LOG2(12), .LATENCY(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_addr_valid(imem_addr_valid),
        .imem_data(d[0]), .imem_data_valid(v[0]), .imem_fault(f[0]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(b[0])
    );
    imem_responder #(.DEPTH_LOG2(12), .LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_addr_valid(imem_addr_valid),
        .imem_data(d[1]), .imem_data_valid(v[1]), .imem_fault(f[1]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(b[1])
    );
    imem_responder #(.DEPTH_LOG2(12), .LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_addr_valid(imem_addr_valid),
        .imem_data(d[2]), .imem_data_valid(v[2]), .imem_fault(f[2]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(b[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        logic [63:0] addr;
        logic [63:0] exp_data;
        logic        exp_fault;
    } vec_t;

    vec_t vecs [9];

    function automatic int lat_of(input int sel);
        case (sel)
            0:       return 2;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [11:0] idx, input logic [63:0] val);
        ld_en   = 1'b1;
        ld_addr = idx;
        ld_data = val;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Raise a request, hold it until the selected responder strobes, and
    // drop it in the strobe cycle. Then confirm that the strobe is single-cycle.
    task automatic do_fetch(input int sel, input logic [63:0] a, input logic [63:0] ed,
                            input logic ef, input string tag);
        int cycles;
        bit seen;
        cycles          = 0;
        seen            = 1'b0;
        imem_addr       = a;
        imem_addr_valid = 1'b1;
        while (!seen && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1 && lat_of(sel) > 1) begin
                check({tag, " busy"}, 64'(b[sel]), 64'd1);
            end
            if (v[sel]) seen = 1'b1;
        end
        check({tag, " latency"}, 64'(cycles), 64'(lat_of(sel)));
        check({tag, " data"}, d[sel], ed);
        check({tag, " fault"}, 64'(f[sel]), 64'(ef));
        imem_addr_valid = 1'b0;
        @(negedge clk);
        check({tag, " strobe low"}, 64'(v[sel]), 64'd0);
        check({tag, " data held"}, d[sel], ed);
        check({tag, " fault low"}, 64'(f[sel]), 64'd0);
    endtask

    initial begin
        vecs[0] = '{0, 64'h28,                  64'hDEAD_BEEF_0123_4567, 1'b0};
        vecs[1] = '{0, 64'h1_0000_0000,         64'd0,                   1'b1};
        vecs[2] = '{0, 64'h08,                  64'd2,                   1'b0};
        vecs[3] = '{0, 64'h7FF8,                64'hA5A5_5A5A_0F0F_F0F0, 1'b0};
        vecs[4] = '{0, 64'h8000,                64'd0,                   1'b1};
        vecs[5] = '{0, 64'h2F,                  64'hDEAD_BEEF_0123_4567, 1'b0};
        vecs[6] = '{1, 64'h10,                  64'd3,                   1'b0};
        vecs[7] = '{2, 64'h28,                  64'hDEAD_BEEF_0123_4567, 1'b0};
        vecs[8] = '{2, 64'h8000_0000_0000_0000, 64'd0,                   1'b1};

        rst_n           = 1'b0;
        imem_addr       = 64'd0;
        imem_addr_valid = 1'b0;
        ld_en           = 1'b0;
        ld_addr         = 12'd0;
        ld_data         = 64'd0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset data %0d", s), d[s], 64'd0);
            check($sformatf("reset valid %0d", s), 64'(v[s]), 64'd0);
            check($sformatf("reset fault %0d", s), 64'(f[s]), 64'd0);
            check($sformatf("reset busy %0d", s), 64'(b[s]), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        load(12'd0,    64'd1);
        load(12'd1,    64'd2);
        load(12'd2,    64'd3);
        load(12'd5,    64'hDEAD_BEEF_0123_4567);
        load(12'd4095, 64'hA5A5_5A5A_0F0F_F0F0);

        for (int i = 0; i < 9; i++) begin
            do_fetch(vecs[i].sel, vecs[i].addr, vecs[i].exp_data, vecs[i].exp_fault,
                     $sformatf("vec%0d", i));
        end

        // LATENCY=1 back-to-back: a new address every cycle, valid stays high.
        imem_addr       = 64'h00;
        imem_addr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("b2b valid %0d", i), 64'(v[1]), 64'd1);
            check($sformatf("b2b data %0d", i), d[1], 64'(i + 1));
            imem_addr = 64'((i + 1) * 8);
        end
        imem_addr_valid = 1'b0;
        @(negedge clk);
        check("b2b valid end", 64'(v[1]), 64'd0);
        check("b2b data end", d[1], 64'd3);

        // LATENCY=3 abort: drop valid after one cycle in WAIT.
        imem_addr       = 64'h08;
        imem_addr_valid = 1'b1;
        @(negedge clk);
        check("abort busy", 64'(b[2]), 64'd1);
        imem_addr_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("abort no strobe %0d", i), 64'(v[2]), 64'd0);
        end
        check("abort idle", 64'(b[2]), 64'd0);
        do_fetch(2, 64'h08, 64'd2, 1'b0, "after abort");

        // LATENCY=3 restart: the address changes just before the count expires.
        imem_addr       = 64'h08;
        imem_addr_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("restart early strobe", 64'(v[2]), 64'd0);
        end
        imem_addr = 64'h10;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i < 3) check($sformatf("restart wait %0d", i), 64'(v[2]), 64'd0);
            else begin
                check("restart strobe", 64'(v[2]), 64'd1);
                check("restart data", d[2], 64'd3);
            end
        end
        imem_addr_valid = 1'b0;
        @(negedge clk);
        check("restart single strobe", 64'(v[2]), 64'd0);

        // A load on the acceptance edge is visible to the RESP read one edge later.
        imem_addr       = 64'h18;
        imem_addr_valid = 1'b1;
        ld_en           = 1'b1;
        ld_addr         = 12'd3;
        ld_data         = 64'h3333;
        @(negedge clk);
        ld_en = 1'b0;
        @(negedge clk);
        check("early load valid", 64'(v[0]), 64'd1);
        check("early load data", d[0], 64'h3333);
        imem_addr_valid = 1'b0;
        @(negedge clk);

        // A load on the RESP-entry edge is not visible to that read.
        imem_addr       = 64'h18;
        imem_addr_valid = 1'b1;
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = 12'd3;
        ld_data = 64'h4444;
        @(negedge clk);
        ld_en = 1'b0;
        check("same-edge load valid", 64'(v[0]), 64'd1);
        check("same-edge load data", d[0], 64'h3333);
        imem_addr_valid = 1'b0;
        @(negedge clk);
        do_fetch(0, 64'h18, 64'h4444, 1'b0, "refetch");

        // Reset in the middle of WAIT drops the request.
        imem_addr       = 64'h08;
        imem_addr_valid = 1'b1;
        @(negedge clk);
        check("pre-reset busy", 64'(b[2]), 64'd1);
        rst_n           = 1'b0;
        imem_addr_valid = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("mid reset data %0d", s), d[s], 64'd0);
            check($sformatf("mid reset valid %0d", s), 64'(v[s]), 64'd0);
            check($sformatf("mid reset busy %0d", s), 64'(b[s]), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post reset no strobe %0d", i), 64'(v[2]), 64'd0);
        end
        do_fetch(2, 64'h28, 64'hDEAD_BEEF_0123_4567, 1'b0, "post reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
